fifo_pop_packer: RTL and testbench

Consumer-side adapter for the pop end of a FIFO with an `empty`/`pop`/`data_out` interface, where `data_out` always shows the head entry. It pops `WIDTH`-bit words while the FIFO is non-empty and packs `RATIO` consecutive words into one wide output beat. Beats leave on a valid/ready stream. A `flush` input emits a partially filled beat. The block sits between a FIFO and a wide downstream consumer.

---
 rtl/fifo_pop_packer.sv | 70 +++++++
 tb/tb_fifo_pop_packer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_packer.sv
// Packs RATIO FIFO words into one wide valid/ready beat; out_valid rises the cycle after the last pop or flush.
// Backpressure: a held beat stalls popping until out_ready, and the handshake cycle may pop the next word into lane 0.
module fifo_pop_packer #(
  parameter int WIDTH  = 8,
  parameter int RATIO  = 4,
  parameter int CNTWID = $clog2(RATIO + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [WIDTH-1:0]        fifo_data,
  output logic                    fifo_pop,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*RATIO-1:0]  out_data,
  output logic [CNTWID-1:0]       out_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                   state, state_nxt;
  logic [CNTWID-1:0]        cnt, cnt_nxt, base_cnt;
  logic [WIDTH*RATIO-1:0]   acc, acc_nxt, base_acc;
  logic                     handshake;

  assign fifo_pop  = !rst && !fifo_empty && (state == FILL || out_ready);
  assign handshake = (state == HOLD) && out_ready;

  assign out_valid = (state == HOLD);
  assign out_data  = (state == HOLD) ? acc : '0;
  assign out_count = (state == HOLD) ? cnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    base_cnt  = cnt;
    base_acc  = acc;
    // A handshake empties the accumulator before the same-cycle pop is placed.
    if (handshake) begin
      state_nxt = FILL;
      base_cnt  = '0;
      base_acc  = '0;
    end
    cnt_nxt = base_cnt;
    acc_nxt = base_acc;
    if (fifo_pop) begin
      cnt_nxt = base_cnt + CNTWID'(1);
      for (int k = 0; k < RATIO; k++) begin
        if (base_cnt == CNTWID'(k)) acc_nxt[k*WIDTH +: WIDTH] = fifo_data;
      end
    end
    if (state == FILL) begin
      if (cnt_nxt == CNTWID'(RATIO)) state_nxt = HOLD;
      if (flush && cnt_nxt != '0)    state_nxt = HOLD;
    end
  end

endmodule

// File: tb/tb_fifo_pop_packer.sv
module tb_fifo_pop_packer;
  localparam int W = 8;
  localparam int R = 4;
  localparam int C = $clog2(R + 1);

  logic           clk = 0;
  logic           rst = 1;
  logic           fifo_empty = 1;
  logic [W-1:0]   fifo_data = '0;
  logic           fifo_pop;
  logic           flush = 0;
  logic           out_valid;
  logic           out_ready = 0;
  logic [W*R-1:0] out_data;
  logic [C-1:0]   out_count;

  int tests = 0;
  int fails = 0;

  // Environment FIFO and reference model: words gathered so far, and the beat on offer.
  logic [W-1:0] q[$];
  logic [W-1:0] cur[$];
  logic [W-1:0] held[$];
  bit           holding = 0;
  logic           exp_pop, exp_valid;
  logic [W*R-1:0] exp_data;
  logic [C-1:0]   exp_cnt;

  fifo_pop_packer #(.WIDTH(W), .RATIO(R)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic f, input logic r, input logic rs);
    @(negedge clk);
    flush = f; out_ready = r; rst = rs;
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() == 0) ? W'($urandom) : q[0];
    #1;
    exp_pop   = !rs && q.size() > 0 && (!holding || r);
    exp_valid = holding;
    exp_data  = '0;
    for (int i = 0; i < held.size(); i++) exp_data[i*W +: W] = held[i];
    exp_cnt   = C'(held.size());
  endtask

  task automatic adv();
    bit was;
    @(posedge clk);
    if (rst) begin
      holding = 0; cur.delete(); held.delete();
    end else begin
      was = holding;
      if (holding && out_ready) begin holding = 0; held.delete(); end
      if (exp_pop) cur.push_back(q.pop_front());
      if (!was && (cur.size() == R || (flush && cur.size() > 0))) begin
        held = cur; cur.delete(); holding = 1;
      end
    end
  endtask

  task automatic test_reset();
    q.push_back(8'h99);
    drive(0, 1, 1);
    tests++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL reset_pop: got %b want 0", fifo_pop); end
    adv();
    drive(0, 1, 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", out_data); end
    tests++; if (out_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", out_count); end
    adv();
    q.delete();
  endtask

  task automatic test_basic_pack();
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0);
      tests++; if (fifo_pop !== 1'b1) begin fails++; $display("FAIL basic_pop%0d: got %b want 1", i, fifo_pop); end
      adv();
    end
    drive(0, 1, 0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    tests++; if (out_data !== 32'h44332211) begin fails++; $display("FAIL basic_data: got %h want 44332211", out_data); end
    tests++; if (out_count !== C'(4)) begin fails++; $display("FAIL basic_count: got %0d want 4", out_count); end
    adv();
  endtask

  task automatic test_backpressure();
    q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB5, 8'hB6};
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0); adv(); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      tests++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL bp_pop%0d: got %b want 0", i, fifo_pop); end
      tests++; if (out_data !== 32'hA4A3A2A1) begin fails++; $display("FAIL bp_data%0d: got %h want a4a3a2a1", i, out_data); end
      adv();
    end
    drive(0, 1, 0);
    tests++; if (fifo_pop !== 1'b1) begin fails++; $display("FAIL bp_hs_pop: got %b want 1", fifo_pop); end
    adv();
    drive(1, 0, 0);
    adv();
    drive(0, 0, 0);
    tests++; if (out_data !== 32'h0000B6B5) begin fails++; $display("FAIL bp_lane0: got %h want 0000b6b5", out_data); end
    tests++; if (out_count !== C'(2)) begin fails++; $display("FAIL bp_count: got %0d want 2", out_count); end
    adv();
    drive(0, 1, 0); adv();
  endtask

  task automatic test_back_to_back();
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0);
      if (i < 8) begin
        tests++; if (fifo_pop !== 1'b1) begin fails++; $display("FAIL b2b_pop%0d: got %b want 1", i, fifo_pop); end
      end
      if (i == 4) begin
        tests++; if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin fails++; $display("FAIL b2b_beat0: got %b/%h want 1/04030201", out_valid, out_data); end
      end
      if (i == 8) begin
        tests++; if (out_valid !== 1'b1 || out_data !== 32'h08070605) begin fails++; $display("FAIL b2b_beat1: got %b/%h want 1/08070605", out_valid, out_data); end
      end
      adv();
    end
  endtask

  task automatic test_partial_flush();
    q = '{8'hAA, 8'hBB};
    drive(0, 1, 0); adv();
    drive(0, 1, 0); adv();
    drive(1, 1, 0); adv();
    drive(0, 0, 0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pf_valid: got %b want 1", out_valid); end
    tests++; if (out_data !== 32'h0000BBAA) begin fails++; $display("FAIL pf_data: got %h want 0000bbaa", out_data); end
    tests++; if (out_count !== C'(2)) begin fails++; $display("FAIL pf_count: got %0d want 2", out_count); end
    adv();
    drive(0, 1, 0); adv();
    drive(1, 1, 0); adv();
    drive(0, 1, 0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pf_empty_flush: got %b want 0", out_valid); end
    adv();
  endtask

  task automatic test_flush_pop();
    q = '{8'h10};
    drive(0, 1, 0); adv();
    q.push_back(8'h20);
    drive(1, 1, 0);
    tests++; if (fifo_pop !== 1'b1) begin fails++; $display("FAIL fp_pop: got %b want 1", fifo_pop); end
    adv();
    drive(0, 0, 0);
    tests++; if (out_data !== 32'h00002010) begin fails++; $display("FAIL fp_data: got %h want 00002010", out_data); end
    tests++; if (out_count !== C'(2)) begin fails++; $display("FAIL fp_count: got %0d want 2", out_count); end
    adv();
    drive(0, 1, 0); adv();
  endtask

  task automatic test_reset_hold();
    q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1};
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0); adv(); end
    drive(0, 1, 1);
    tests++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL rh_pop: got %b want 0", fifo_pop); end
    adv();
    drive(0, 1, 0);
    tests++; if (out_valid !== 1'b0 || out_data !== '0) begin fails++; $display("FAIL rh_cleared: got %b/%h want 0/0", out_valid, out_data); end
    adv();
    drive(1, 1, 0); adv();
    drive(0, 0, 0);
    tests++; if (out_data !== 32'h000000D1 || out_count !== C'(1)) begin fails++; $display("FAIL rh_restart: got %h/%0d want 000000d1/1", out_data, out_count); end
    adv();
    drive(0, 1, 0); adv();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) != 0 && q.size() < 6) q.push_back(W'($urandom));
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
      tests++; if (fifo_pop !== exp_pop) begin fails++; $display("FAIL rnd_pop@%0d: got %b want %b", n, fifo_pop, exp_pop); end
      tests++; if (out_valid !== exp_valid) begin fails++; $display("FAIL rnd_valid@%0d: got %b want %b", n, out_valid, exp_valid); end
      tests++; if (out_data !== exp_data) begin fails++; $display("FAIL rnd_data@%0d: got %h want %h", n, out_data, exp_data); end
      tests++; if (out_count !== exp_cnt) begin fails++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, out_count, exp_cnt); end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_backpressure();
    test_back_to_back();
    test_partial_flush();
    test_flush_pop();
    test_reset_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
